// File: rtl/gbox_pkg.sv
// Shared types and constants for the gearbox TX serializer slice.
package gbox_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        BYPASS
    } gbox_ser_state_t;

    localparam logic [3:0] GBOX_MIN_RATE = 4'd3;
    localparam logic [3:0] GBOX_MAX_RATE = 4'd10;

    // A word width is usable when it lies between the minimum rate and the
    // configured maximum word width of the instance.
    function automatic logic gbox_rate_ok(input logic [3:0] rate, input logic [3:0] max_rate);
        return (rate >= GBOX_MIN_RATE) && (rate <= max_rate);
    endfunction

endpackage

// File: rtl/gbox_tx_err_flags.sv
// Sticky underrun / alignment error flags; a set on the same edge as a
// clear keeps the flag set.
module gbox_tx_err_flags (
    input  logic clk_i,
    input  logic rst_i,
    input  logic set_underrun_i,
    input  logic set_align_i,
    input  logic clr_i,
    output logic underrun_o,
    output logic align_err_o
);

    logic underrun_q, underrun_d;
    logic align_err_q, align_err_d;

    // Next value: set beats clear, otherwise hold.
    always_comb begin
        underrun_d  = underrun_q;
        align_err_d = align_err_q;
        if (set_underrun_i) begin
            underrun_d = 1'b1;
        end else if (clr_i) begin
            underrun_d = 1'b0;
        end
        if (set_align_i) begin
            align_err_d = 1'b1;
        end else if (clr_i) begin
            align_err_d = 1'b0;
        end
    end

    // Flag registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            underrun_q  <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            underrun_q  <= underrun_d;
            align_err_q <= align_err_d;
        end
    end

    assign underrun_o  = underrun_q;
    assign align_err_o = align_err_q;

endmodule

// File: rtl/gbox_tx_serializer.sv
// TX gearbox serializer: captures a parallel word on each word_load_en pulse
// and shifts it out LSB-first on fast_clk, with word-aligned output enable,
// sticky underrun/alignment flags and a direct-drive bypass path.
module gbox_tx_serializer
    import gbox_pkg::*;
#(
    parameter int unsigned DATA_W   = 10,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic              fast_clk,
    input  logic              reset,
    input  logic [3:0]        rate_sel,
    input  logic              cfg_done,
    input  logic              cfg_bypass,
    input  logic              word_load_en,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_data_valid,
    input  logic              tx_oe_in,
    input  logic              bypass_dq,
    input  logic              err_clr,
    output logic              tx_dq,
    output logic              tx_oe,
    output logic              tx_busy,
    output logic              tx_underrun,
    output logic              tx_align_err
);

    localparam logic [3:0] RATE_MAX = 4'(DATA_W);

    gbox_ser_state_t   state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        rate_lat_q, rate_lat_d;
    logic              tx_dq_q, tx_dq_d;
    logic              tx_oe_q, tx_oe_d;

    logic              rate_ok;
    logic [3:0]        last_bit;
    logic [DATA_W-1:0] load_word;
    logic              do_load;
    logic              set_underrun;
    logic              set_align;

    assign rate_ok  = gbox_rate_ok(rate_sel, RATE_MAX);
    assign last_bit = rate_lat_q - 4'd1;

    // Word to capture: bits beyond the latched width, or the whole word on
    // underrun, are replaced by the idle level.
    always_comb begin
        load_word = {DATA_W{IDLE_BIT}};
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (tx_data_valid && (i < 32'(rate_lat_q))) begin
                load_word[i] = tx_data[i];
            end
        end
    end

    // Next-state, shift path and error-set decisions.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        rate_lat_d   = rate_lat_q;
        tx_dq_d      = tx_dq_q;
        tx_oe_d      = tx_oe_q;
        do_load      = 1'b0;
        set_underrun = 1'b0;
        set_align    = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_dq_d = IDLE_BIT;
                tx_oe_d = 1'b0;
                if (cfg_done && cfg_bypass) begin
                    state_d = BYPASS;
                end else if (cfg_done && rate_ok) begin
                    state_d    = ARM;
                    rate_lat_d = rate_sel;
                end
            end

            ARM: begin
                tx_dq_d = IDLE_BIT;
                tx_oe_d = 1'b0;
                if (!cfg_done) begin
                    state_d = IDLE;
                end else if (cfg_bypass) begin
                    state_d = BYPASS;
                end else if (rate_sel != rate_lat_q) begin
                    state_d = IDLE;
                end else if (word_load_en) begin
                    state_d = RUN;
                    do_load = 1'b1;
                end
            end

            RUN: begin
                if (!cfg_done || cfg_bypass || (rate_sel != rate_lat_q)) begin
                    // Exit priority: lost config, then bypass, then rate change.
                    if (!cfg_done) begin
                        state_d = IDLE;
                    end else if (cfg_bypass) begin
                        state_d = BYPASS;
                    end else begin
                        state_d = IDLE;
                    end
                    tx_dq_d   = IDLE_BIT;
                    tx_oe_d   = 1'b0;
                    shift_d   = {DATA_W{IDLE_BIT}};
                    bit_cnt_d = '0;
                end else if (word_load_en) begin
                    do_load = 1'b1;
                    if (bit_cnt_q != last_bit) begin
                        set_align = 1'b1;
                    end
                end else begin
                    tx_dq_d = shift_q[0];
                    shift_d = {IDLE_BIT, shift_q[DATA_W-1:1]};
                    if (bit_cnt_q != 4'hF) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (bit_cnt_q == last_bit) begin
                        set_align = 1'b1;
                    end
                end
            end

            BYPASS: begin
                if (!cfg_bypass || !cfg_done) begin
                    state_d = IDLE;
                    tx_dq_d = IDLE_BIT;
                    tx_oe_d = 1'b0;
                end else begin
                    tx_dq_d = bypass_dq;
                    tx_oe_d = tx_oe_in;
                end
            end

            default: begin
                state_d = IDLE;
                tx_dq_d = IDLE_BIT;
                tx_oe_d = 1'b0;
            end
        endcase

        if (do_load) begin
            tx_dq_d      = load_word[0];
            shift_d      = {IDLE_BIT, load_word[DATA_W-1:1]};
            bit_cnt_d    = '0;
            tx_oe_d      = tx_oe_in;
            set_underrun = !tx_data_valid;
        end
    end

    // State, shift path and output registers.
    always_ff @(posedge fast_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            rate_lat_q <= GBOX_MIN_RATE;
            tx_dq_q    <= IDLE_BIT;
            tx_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            rate_lat_q <= rate_lat_d;
            tx_dq_q    <= tx_dq_d;
            tx_oe_q    <= tx_oe_d;
        end
    end

    gbox_tx_err_flags u_err_flags (
        .clk_i          (fast_clk),
        .rst_i          (reset),
        .set_underrun_i (set_underrun),
        .set_align_i    (set_align),
        .clr_i          (err_clr),
        .underrun_o     (tx_underrun),
        .align_err_o    (tx_align_err)
    );

    assign tx_dq   = tx_dq_q;
    assign tx_oe   = tx_oe_q;
    assign tx_busy = (state_q == RUN);

endmodule

// File: tb/tb_gbox_tx_serializer.sv
// Self-checking bench for gbox_tx_serializer: directed scenarios plus random
// word streams compared against a timeline model of the serial output.
module tb_gbox_tx_serializer;

    localparam logic IDLE_BIT = 1'b0;

    logic       fast_clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rate_sel = 4'd4;
    logic       cfg_done = 1'b0;
    logic       cfg_bypass = 1'b0;
    logic       word_load_en = 1'b0;
    logic [9:0] tx_data = '0;
    logic       tx_data_valid = 1'b0;
    logic       tx_oe_in = 1'b0;
    logic       bypass_dq = 1'b0;
    logic       err_clr = 1'b0;
    logic       tx_dq, tx_oe, tx_busy, tx_underrun, tx_align_err;

    int total = 0;
    int bad = 0;

    // Stream description and captured / expected per-edge values.
    int unsigned rate, n_loads, span;
    int unsigned load_t[16];
    logic [9:0]  load_w[16];
    logic        load_v[16];
    logic        load_oe[16];
    logic obs_dq[256], obs_oe[256], obs_busy[256], obs_und[256], obs_aln[256];
    logic exp_dq[256], exp_oe[256], exp_und[256], exp_aln[256];

    gbox_tx_serializer #(.DATA_W(10), .IDLE_BIT(IDLE_BIT)) dut (
        .fast_clk      (fast_clk),
        .reset         (reset),
        .rate_sel      (rate_sel),
        .cfg_done      (cfg_done),
        .cfg_bypass    (cfg_bypass),
        .word_load_en  (word_load_en),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_oe_in      (tx_oe_in),
        .bypass_dq     (bypass_dq),
        .err_clr       (err_clr),
        .tx_dq         (tx_dq),
        .tx_oe         (tx_oe),
        .tx_busy       (tx_busy),
        .tx_underrun   (tx_underrun),
        .tx_align_err  (tx_align_err)
    );

    always #5 fast_clk = ~fast_clk;

    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; cfg_done = 1'b0; cfg_bypass = 1'b0; word_load_en = 1'b0;
        err_clr = 1'b0; tx_data_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Configure, arm, then play the load schedule edge by edge, capturing outputs.
    task automatic drive_stream();
        int unsigned j;
        j = 0;
        cfg_done = 1'b1; cfg_bypass = 1'b0; rate_sel = 4'(rate); word_load_en = 1'b0;
        tick();
        for (int unsigned e = 0; e < span; e++) begin
            if (j < n_loads && load_t[j] == e) begin
                word_load_en = 1'b1; tx_data = load_w[j];
                tx_data_valid = load_v[j]; tx_oe_in = load_oe[j];
                j++;
            end else begin
                word_load_en = 1'b0; tx_data = 10'($urandom);
                tx_data_valid = 1'($urandom); tx_oe_in = 1'($urandom);
            end
            tick();
            obs_dq[e] = tx_dq; obs_oe[e] = tx_oe; obs_busy[e] = tx_busy;
            obs_und[e] = tx_underrun; obs_aln[e] = tx_align_err;
        end
        word_load_en = 1'b0;
    endtask

    // Timeline model: after edge e the line carries bit (e - L) of the latest
    // word loaded at edge L, or idle once that word is used up.
    task automatic model_stream();
        int unsigned j, k, nxt, lim;
        for (int unsigned e = 0; e < span; e++) begin
            j = 0;
            for (int unsigned i = 0; i < n_loads; i++) if (load_t[i] <= e) j = i;
            k = e - load_t[j];
            exp_dq[e] = (k < rate && load_v[j]) ? load_w[j][k] : IDLE_BIT;
            exp_oe[e] = load_oe[j];
            exp_und[e] = 1'b0;
            for (int unsigned i = 0; i <= j; i++) if (!load_v[i]) exp_und[e] = 1'b1;
            exp_aln[e] = 1'b0;
            for (int unsigned i = 0; i < n_loads; i++) begin
                nxt = (i + 1 < n_loads) ? load_t[i+1] : 32'hFFFF;
                lim = (nxt < load_t[i] + rate) ? nxt : load_t[i] + rate;
                if (nxt != load_t[i] + rate && lim <= e) exp_aln[e] = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_done = 1'b1; word_load_en = 1'b1; tx_data = '1;
        tx_data_valid = 1'b0; tx_oe_in = 1'b1; bypass_dq = 1'b1;
        tick(); tick();
        total++; if (tx_dq !== IDLE_BIT) begin bad++; $display("FAIL reset_dq got=%b exp=%b", tx_dq, IDLE_BIT); end
        total++; if (tx_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", tx_oe); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
        total++; if (tx_underrun !== 1'b0) begin bad++; $display("FAIL reset_und got=%b exp=0", tx_underrun); end
        total++; if (tx_align_err !== 1'b0) begin bad++; $display("FAIL reset_aln got=%b exp=0", tx_align_err); end
        reset = 1'b0; word_load_en = 1'b0;
    endtask

    task automatic test_pattern4();
        logic [3:0] pat;
        pat = 4'b1011;
        do_reset();
        rate = 4; n_loads = 4; span = 16;
        for (int unsigned i = 0; i < 4; i++) begin
            load_t[i] = 4 * i; load_w[i] = {6'($urandom), pat}; load_v[i] = 1'b1; load_oe[i] = 1'b1;
        end
        drive_stream();
        for (int unsigned e = 0; e < span; e++) begin
            total++; if (obs_dq[e] !== pat[e % 4]) begin bad++; $display("FAIL pat4_dq e=%0d got=%b exp=%b", e, obs_dq[e], pat[e % 4]); end
            total++; if (obs_und[e] !== 1'b0 || obs_aln[e] !== 1'b0) begin bad++; $display("FAIL pat4_flags e=%0d got=%b%b exp=00", e, obs_und[e], obs_aln[e]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] bits;
        bits = {10'h15A, 10'h2A5};
        do_reset();
        rate = 10; n_loads = 2; span = 20;
        load_t[0] = 0;  load_w[0] = 10'h2A5; load_v[0] = 1'b1; load_oe[0] = 1'b1;
        load_t[1] = 10; load_w[1] = 10'h15A; load_v[1] = 1'b1; load_oe[1] = 1'b0;
        drive_stream();
        for (int unsigned e = 0; e < span; e++) begin
            total++; if (obs_dq[e] !== bits[e]) begin bad++; $display("FAIL b2b_dq e=%0d got=%b exp=%b", e, obs_dq[e], bits[e]); end
            total++; if (obs_busy[e] !== 1'b1) begin bad++; $display("FAIL b2b_busy e=%0d got=%b exp=1", e, obs_busy[e]); end
            total++; if (obs_oe[e] !== (e < 10)) begin bad++; $display("FAIL b2b_oe e=%0d got=%b exp=%b", e, obs_oe[e], e < 10); end
        end
        total++; if (obs_aln[19] !== 1'b0) begin bad++; $display("FAIL b2b_aln got=%b exp=0", obs_aln[19]); end
    endtask

    task automatic test_random_streams();
        int unsigned t, g;
        for (int unsigned it = 0; it < 8; it++) begin
            do_reset();
            rate = $urandom_range(3, 10);
            n_loads = $urandom_range(3, 8);
            t = 0;
            for (int unsigned i = 0; i < n_loads; i++) begin
                load_t[i] = t; load_w[i] = 10'($urandom);
                load_v[i] = ($urandom_range(0, 9) != 0); load_oe[i] = 1'($urandom);
                g = $urandom_range(0, 7);
                t += (g == 0) ? rate - 1 : (g == 1) ? rate + 2 : rate;
            end
            span = load_t[n_loads-1] + rate + $urandom_range(0, 3);
            drive_stream();
            model_stream();
            for (int unsigned e = 0; e < span; e++) begin
                total++;
                if (obs_dq[e] !== exp_dq[e] || obs_oe[e] !== exp_oe[e] || obs_busy[e] !== 1'b1 ||
                    obs_und[e] !== exp_und[e] || obs_aln[e] !== exp_aln[e]) begin
                    bad++;
                    $display("FAIL rand it=%0d rate=%0d e=%0d got dq/oe/busy/und/aln=%b%b%b%b%b exp=%b%b1%b%b",
                             it, rate, e, obs_dq[e], obs_oe[e], obs_busy[e], obs_und[e], obs_aln[e],
                             exp_dq[e], exp_oe[e], exp_und[e], exp_aln[e]);
                end
            end
        end
    endtask

    task automatic test_underrun();
        do_reset();
        rate = 5; n_loads = 3; span = 15;
        for (int unsigned i = 0; i < 3; i++) begin
            load_t[i] = 5 * i; load_w[i] = 10'h3FF; load_v[i] = (i != 1); load_oe[i] = 1'b1;
        end
        drive_stream();
        for (int unsigned e = 0; e < span; e++) begin
            total++; if (obs_dq[e] !== ((e >= 5 && e < 10) ? IDLE_BIT : 1'b1)) begin bad++; $display("FAIL und_dq e=%0d got=%b", e, obs_dq[e]); end
            total++; if (obs_und[e] !== (e >= 5)) begin bad++; $display("FAIL und_flag e=%0d got=%b exp=%b", e, obs_und[e], e >= 5); end
        end
        // Word runs out on this edge while clearing: alignment set wins, underrun clears.
        err_clr = 1'b1;
        tick();
        total++; if (tx_underrun !== 1'b0) begin bad++; $display("FAIL und_clr got=%b exp=0", tx_underrun); end
        total++; if (tx_align_err !== 1'b1) begin bad++; $display("FAIL set_over_clr got=%b exp=1", tx_align_err); end
        tick();
        total++; if (tx_align_err !== 1'b0) begin bad++; $display("FAIL aln_clr got=%b exp=0", tx_align_err); end
        err_clr = 1'b0;
    endtask

    task automatic test_align();
        do_reset();
        rate = 8; n_loads = 2; span = 13;
        load_t[0] = 0; load_w[0] = 10'($urandom); load_v[0] = 1'b1; load_oe[0] = 1'b1;
        load_t[1] = 5; load_w[1] = 10'($urandom); load_v[1] = 1'b1; load_oe[1] = 1'b1;
        drive_stream();
        model_stream();
        for (int unsigned e = 0; e < span; e++) begin
            total++; if (obs_dq[e] !== exp_dq[e]) begin bad++; $display("FAIL aln_dq e=%0d got=%b exp=%b", e, obs_dq[e], exp_dq[e]); end
            total++; if (obs_aln[e] !== (e >= 5)) begin bad++; $display("FAIL aln_flag e=%0d got=%b exp=%b", e, obs_aln[e], e >= 5); end
        end
    endtask

    task automatic test_bypass();
        logic b, o;
        logic [3:0] bad_rates[3];
        bad_rates[0] = 4'd2; bad_rates[1] = 4'd11; bad_rates[2] = 4'd0;
        do_reset();
        cfg_done = 1'b1; cfg_bypass = 1'b1;
        tick();
        for (int unsigned i = 0; i < 16; i++) begin
            b = 1'($urandom); o = 1'($urandom);
            bypass_dq = b; tx_oe_in = o; word_load_en = 1'($urandom);
            tick();
            total++; if (tx_dq !== b || tx_oe !== o || tx_busy !== 1'b0) begin
                bad++; $display("FAIL byp i=%0d got dq/oe/busy=%b%b%b exp=%b%b0", i, tx_dq, tx_oe, tx_busy, b, o);
            end
        end
        bypass_dq = 1'b1; tx_oe_in = 1'b1; word_load_en = 1'b0; rate_sel = 4'd2; cfg_bypass = 1'b0;
        tick();
        total++; if (tx_dq !== IDLE_BIT || tx_oe !== 1'b0) begin bad++; $display("FAIL byp_exit got dq/oe=%b%b exp=%b0", tx_dq, tx_oe, IDLE_BIT); end
        for (int unsigned r = 0; r < 3; r++) begin
            rate_sel = bad_rates[r];
            for (int unsigned i = 0; i < 6; i++) begin
                word_load_en = (i % 2 == 1); tx_data = '1; tx_data_valid = 1'b1;
                tick();
                total++; if (tx_busy !== 1'b0 || tx_dq !== IDLE_BIT || tx_oe !== 1'b0) begin
                    bad++; $display("FAIL bad_rate rate=%0d got busy/dq/oe=%b%b%b exp=0%b0", bad_rates[r], tx_busy, tx_dq, tx_oe, IDLE_BIT);
                end
            end
        end
        word_load_en = 1'b0;
    endtask

    // Exit mid-word via reset, rate change or lost config, then restart cleanly.
    task automatic test_exit();
        for (int unsigned m = 0; m < 3; m++) begin
            do_reset();
            rate = 8; n_loads = 1; span = 3;
            load_t[0] = 0; load_w[0] = 10'h3FF; load_v[0] = 1'b1; load_oe[0] = 1'b1;
            drive_stream();
            if (m == 0) reset = 1'b1;
            else if (m == 1) rate_sel = 4'd6;
            else cfg_done = 1'b0;
            tick();
            total++; if (tx_dq !== IDLE_BIT || tx_oe !== 1'b0 || tx_busy !== 1'b0) begin
                bad++; $display("FAIL exit m=%0d got dq/oe/busy=%b%b%b exp=%b00", m, tx_dq, tx_oe, tx_busy, IDLE_BIT);
            end
            reset = 1'b0;
            rate = 6; n_loads = 2; span = 12;
            load_t[0] = 0; load_w[0] = 10'($urandom); load_v[0] = 1'b1; load_oe[0] = 1'b1;
            load_t[1] = 6; load_w[1] = 10'($urandom); load_v[1] = 1'b1; load_oe[1] = 1'b0;
            drive_stream();
            model_stream();
            for (int unsigned e = 0; e < span; e++) begin
                total++;
                if (obs_dq[e] !== exp_dq[e] || obs_oe[e] !== exp_oe[e] || obs_busy[e] !== 1'b1 || obs_aln[e] !== 1'b0) begin
                    bad++; $display("FAIL restart m=%0d e=%0d got dq/oe/busy/aln=%b%b%b%b exp=%b%b10",
                                    m, e, obs_dq[e], obs_oe[e], obs_busy[e], obs_aln[e], exp_dq[e], exp_oe[e]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pattern4();
        test_back_to_back();
        test_random_streams();
        test_underrun();
        test_align();
        test_bypass();
        test_exit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gbox_tx_serializer.md
Name: gbox_tx_serializer

Overview:
- TX-side gearbox stage directly downstream of the gearbox clock generator, in the fast_clk domain.
- On each clock-generator `word_load_en` pulse it captures a parallel core-domain word (rate_sel bits wide) and shifts it out LSB-first, one bit per fast_clk.
- It also aligns the output-enable to word boundaries, flags underrun and misalignment, and supports a bypass path for direct pin drive.

Parameters:
- DATA_W, 10, maximum word width; rate_sel must not exceed it.
- IDLE_BIT, 1'b0, level driven on tx_dq when idle or on underrun.

Ports:
- fast_clk  in  1  serial bit clock, same clock that drives the clock generator.
- reset  in  1  synchronous, active-high reset.
- rate_sel  in  4  word width in bits; valid range 3..DATA_W.
- cfg_done  in  1  configuration complete; low forces IDLE.
- cfg_bypass  in  1  bypass mode; tx_dq follows bypass_dq.
- word_load_en  in  1  one-fast_clk pulse per word from the clock generator.
- tx_data  in  DATA_W  parallel word from the fabric; stable around word_load_en. Bits above rate_sel-1 are ignored.
- tx_data_valid  in  1  tx_data holds real data this word.
- tx_oe_in  in  1  requested output enable.
- bypass_dq  in  1  direct data in bypass mode.
- err_clr  in  1  clears the sticky error flags.
- tx_dq  out  1  serial data, registered.
- tx_oe  out  1  output enable, registered, word-aligned.
- tx_busy  out  1  high in RUN.
- tx_underrun  out  1  sticky error flag.
- tx_align_err  out  1  sticky error flag.

Behaviour:
- Reset (sampled on fast_clk edge): state=IDLE, shift_reg=0, bit_cnt=0, tx_dq=IDLE_BIT, tx_oe=0, tx_busy=0, tx_underrun=0, tx_align_err=0.
- States: IDLE, ARM, RUN, BYPASS. tx_busy is high only in RUN.
- rate_ok = (rate_sel >= 3) && (rate_sel <= DATA_W).
- IDLE:
  - cfg_done && cfg_bypass -> BYPASS.
  - cfg_done && !cfg_bypass && rate_ok -> ARM, latching rate_lat = rate_sel.
  - While in IDLE: tx_dq=IDLE_BIT, tx_oe=0.
- ARM: hold idle outputs; on word_load_en -> RUN and perform a load.
- Load (one fast_clk edge):
  - tx_dq <= word[0], shift_reg <= word >> 1, bit_cnt <= 0.
  - tx_oe <= tx_oe_in.
  - word = tx_data if tx_data_valid, else all bits IDLE_BIT; in the latter case tx_underrun <= 1.
- Latency: bit k of the word appears on tx_dq in the cycle following edge N+k, where N is the edge at which word_load_en is sampled high.
- RUN, no load:
  - tx_dq <= shift_reg[0], shift_reg <= {IDLE_BIT, shift_reg[DATA_W-1:1]}, bit_cnt <= bit_cnt+1.
  - Saturate bit_cnt at 15.
  - tx_oe holds its value.
- RUN, word_load_en:
  - Always load.
  - If bit_cnt != rate_lat-1 (early or late pulse): tx_align_err <= 1. Data is not dropped; the new word starts immediately.
- RUN, bit_cnt reaches rate_lat-1 with no load on the next edge: continue shifting IDLE_BIT and set tx_align_err on that edge.
- RUN exit conditions (priority, first match wins):
  1. !cfg_done -> IDLE.
  2. cfg_bypass -> BYPASS.
  3. rate_sel != rate_lat -> IDLE.
  - On any exit, outputs go to idle values on the same edge.
- BYPASS:
  - tx_dq <= bypass_dq and tx_oe <= tx_oe_in every cycle (1-cycle latency).
  - !cfg_bypass or !cfg_done -> IDLE.
- Sticky flags:
  - err_clr=1 clears both flags.
  - If err_clr and a set condition occur on the same edge, set wins.
- Reset asserted mid-word: all state is discarded and the next word restarts from ARM.

Decomposition:
- Shared package gbox_pkg holds:
  - typedef enum logic [1:0] {IDLE, ARM, RUN, BYPASS} gbox_ser_state_t;
  - constants GBOX_MIN_RATE=3, GBOX_MAX_RATE=10.
- One sub-module: gbox_tx_err_flags, containing the two sticky flags with set-over-clear priority.
- Shift path and FSM stay in the top module.

Test Plan:
- rate_sel=4, tx_data=4'b1011 valid, word_load_en every 4 cycles -> tx_dq sequence 1,1,0,1 repeating, starting 1 cycle after the load edge; no error flags.
- rate_sel=10, tx_data=10'h2A5 then 10'h15A back-to-back -> 20 bits LSB-first with no gap; tx_busy=1 throughout.
- tx_data_valid=0 at one load -> rate_sel bits of IDLE_BIT, tx_underrun=1 and held; err_clr pulse -> tx_underrun=0.
- rate_sel=8, word_load_en arrives after 5 bits -> new word starts, tx_align_err=1.
- cfg_bypass=1, bypass_dq toggles -> tx_dq equals bypass_dq delayed by 1 cycle; rate_sel=2 with cfg_bypass=0 -> FSM stays in IDLE.
- reset asserted mid-word, or rate_sel changed 8->6 in RUN -> next edge gives tx_dq=IDLE_BIT, tx_oe=0, tx_busy=0; the next load restarts cleanly.
